// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU constants and the command word used by the ALU
// command sequencer.
package alu_seq_pkg;

  localparam int ALU_W   = 8;
  localparam int ALU_LAT = 1;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDK = 2'b10;
  localparam logic [1:0] OP_SUBK = 2'b11;

  localparam logic [ALU_W-1:0] ALU_K = 8'hAA;

  typedef struct packed {
    logic [1:0]       sel;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-port and result signals of the ALU command sequencer.
// The master side is the upstream producer/consumer plus the ALU output.
interface alu_op_sequencer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    import alu_seq_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [1:0]               cmd_sel;
    logic [W-1:0]             cmd_a;
    logic [W-1:0]             cmd_b;
    logic [1:0]               alu_sel;
    logic [W-1:0]             alu_in1;
    logic [W-1:0]             alu_in2;
    logic [W-1:0]             alu_out;
    logic                     res_valid;
    logic                     res_ready;
    logic [W-1:0]             res_data;
    logic [1:0]               res_sel;
    logic [$clog2(DEPTH):0]   cmd_count;

    modport master (
        output cmd_valid, cmd_sel, cmd_a, cmd_b, res_ready, alu_out,
        input  cmd_ready, alu_sel, alu_in1, alu_in2, res_valid, res_data, res_sel, cmd_count
    );

    modport slave (
        input  cmd_valid, cmd_sel, cmd_a, cmd_b, res_ready, alu_out,
        output cmd_ready, alu_sel, alu_in1, alu_in2, res_valid, res_data, res_sel, cmd_count
    );
endinterface

// File: rtl/alu_op_sequencer_sync_fifo.sv
// Synchronous FIFO with extra-bit pointers; the head reads as zero when empty
// so storage needs no reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];
endmodule

// File: rtl/alu_op_sequencer.sv
// Buffers ALU commands, issues at most one per cycle into the one-cycle ALU
// and queues its results so the ALU can sit in a back-pressured pipeline.
module alu_op_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);
    import alu_seq_pkg::*;

    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int RES_DEPTH = ALU_LAT + 1;
    localparam int RCW       = $clog2(RES_DEPTH) + 1;

    typedef struct packed {
        logic [1:0]   sel;
        logic [W-1:0] data;
    } res_t;

    cmd_t           cmd_wr;
    cmd_t           cmd_head;
    logic           cmd_full;
    logic           cmd_empty;
    logic [CW-1:0]  cmd_cnt;
    logic           issue;
    res_t           res_wr;
    res_t           res_head;
    logic           res_full;
    logic           res_empty;
    logic           res_pop;
    logic [RCW-1:0] res_cnt;
    logic [RCW:0]   outstanding;
    logic           vld_p1;
    logic [1:0]     sel_p1;

    assign cmd_wr = '{sel: bus.cmd_sel, a: bus.cmd_a, b: bus.cmd_b};

    sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid && !cmd_full),
        .wdata (cmd_wr),
        .pop   (issue),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_cnt)
    );

    // Results in flight plus queued must stay within the result FIFO after this edge.
    assign res_pop     = !res_empty && bus.res_ready;
    assign outstanding = {{RCW{1'b0}}, vld_p1} + {1'b0, res_cnt} - {{RCW{1'b0}}, res_pop};
    assign issue       = !cmd_empty && (outstanding < (RCW+1)'(RES_DEPTH));

    assign bus.alu_sel = cmd_head.sel;
    assign bus.alu_in1 = cmd_head.a;
    assign bus.alu_in2 = cmd_head.b;

    // p1: command is inside the ALU register; its result appears on alu_out
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= issue;
    end

    always_ff @(posedge clk) begin
        if (issue) sel_p1 <= cmd_head.sel;
    end

    assign res_wr = '{sel: sel_p1, data: bus.alu_out};

    sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p1),
        .wdata (res_wr),
        .pop   (res_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty),
        .count (res_cnt)
    );

    assign bus.cmd_ready = !cmd_full;
    assign bus.cmd_count = cmd_cnt;
    assign bus.res_valid = !res_empty;
    assign bus.res_data  = res_head.data;
    assign bus.res_sel   = res_head.sel;

    a_no_res_overflow: assert property (@(posedge clk) disable iff (rst)
        !(vld_p1 && res_full && !res_pop));
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural one-cycle ALU.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_op_sequencer_if #(.W(8), .DEPTH(4)) bus ();

    alu_op_sequencer #(.DEPTH(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Registered ALU sharing the sequencer reset.
    always_ff @(posedge clk) begin
        if (rst) bus.alu_out <= 8'h00;
        else begin
            case (bus.alu_sel)
                OP_ADD:  bus.alu_out <= bus.alu_in1 + bus.alu_in2;
                OP_SUB:  bus.alu_out <= bus.alu_in1 - bus.alu_in2;
                OP_ADDK: bus.alu_out <= bus.alu_in1 + ALU_K;
                default: bus.alu_out <= bus.alu_in2 - ALU_K;
            endcase
        end
    end

    logic [1:0] t_sel [8] = '{OP_ADD, OP_SUB, OP_ADDK, OP_SUBK, OP_ADD, OP_SUB, OP_ADD, OP_SUBK};
    logic [7:0] t_a   [8] = '{8'h20, 8'h10, 8'h56, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h11};
    logic [7:0] t_b   [8] = '{8'h03, 8'h20, 8'h00, 8'hFF, 8'h01, 8'h01, 8'h02, 8'hAB};
    logic [7:0] t_res [8] = '{8'h23, 8'hF0, 8'h00, 8'h55, 8'h00, 8'h7F, 8'h03, 8'h01};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_sel   = s;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
    endtask

    task automatic idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_sel   = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.res_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h want 00", bus.res_data); end
        checks++; if (bus.res_sel !== 2'b00) begin errors++; $display("FAIL reset_res_sel: got %b want 00", bus.res_sel); end
        checks++; if (bus.cmd_count !== 3'd0) begin errors++; $display("FAIL reset_cmd_count: got %0d want 0", bus.cmd_count); end
        checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2} !== 18'h0) begin errors++; $display("FAIL reset_alu_ports: got %h want 0", {bus.alu_sel, bus.alu_in1, bus.alu_in2}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_add();
        bus.res_ready = 1'b1;
        drive(OP_ADD, 8'h10, 8'h05);              // cycle 0
        tick();
        idle();                                   // cycle 1
        checks++; if (bus.cmd_count !== 3'd1) begin errors++; $display("FAIL add_count_c1: got %0d want 1", bus.cmd_count); end
        checks++; if ({bus.alu_sel, bus.alu_in1, bus.alu_in2} !== {2'b00, 8'h10, 8'h05}) begin errors++; $display("FAIL add_alu_head: got %h want %h", {bus.alu_sel, bus.alu_in1, bus.alu_in2}, {2'b00, 8'h10, 8'h05}); end
        tick();                                   // cycle 2
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.cmd_count !== 3'd0) begin errors++; $display("FAIL add_count_c2: got %0d want 0", bus.cmd_count); end
        tick();                                   // cycle 3
        checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL add_valid_c3: got %b want 1", bus.res_valid); end
        checks++; if (bus.res_data !== 8'h15) begin errors++; $display("FAIL add_data: got %h want 15", bus.res_data); end
        checks++; if (bus.res_sel !== OP_ADD) begin errors++; $display("FAIL add_sel: got %b want 00", bus.res_sel); end
        tick();                                   // cycle 4
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL add_popped: got %b want 0", bus.res_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [1:0] bs [3];
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic [7:0] br [3];
        bs = '{OP_SUB, OP_ADDK, OP_SUBK};
        ba = '{8'h05, 8'h60, 8'h99};
        bb = '{8'h10, 8'h77, 8'h00};
        br = '{8'hF5, 8'h0A, 8'h56};
        bus.res_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 3) drive(bs[c], ba[c], bb[c]);
            else idle();
            if (c == 2) begin
                checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b want 0", bus.res_valid); end
            end
            if (c >= 3 && c < 6) begin
                checks++;
                if (bus.res_valid !== 1'b1 || bus.res_data !== br[c-3] || bus.res_sel !== bs[c-3]) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got v=%b d=%h s=%b want v=1 d=%h s=%b", c-3, bus.res_valid, bus.res_data, bus.res_sel, br[c-3], bs[c-3]);
                end
            end
            if (c == 6) begin
                checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_valid: got %b want 0", bus.res_valid); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int n;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_push%0d: got %b want 1", i, bus.cmd_ready); end
            drive(t_sel[i], t_a[i], t_b[i]);
            tick();
        end
        idle();
        checks++; if (bus.cmd_count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d want 4", bus.cmd_count); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_full: got %b want 0", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== t_res[0]) begin errors++; $display("FAIL stall_head: got v=%b d=%h want v=1 d=%h", bus.res_valid, bus.res_data, t_res[0]); end
        tick(); tick();
        checks++; if (bus.cmd_count !== 3'd4) begin errors++; $display("FAIL stall_count_hold: got %0d want 4", bus.cmd_count); end
        bus.res_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            if (bus.res_valid) begin
                checks++;
                if (bus.res_data !== t_res[n] || bus.res_sel !== t_sel[n]) begin errors++; $display("FAIL stall_drain%0d: got d=%h s=%b want d=%h s=%b", n, bus.res_data, bus.res_sel, t_res[n], t_sel[n]); end
                n++;
            end
            tick();
        end
        checks++; if (n != 6) begin errors++; $display("FAIL stall_drain_count: got %0d want 6", n); end
        bus.res_ready = 1'b0;
        tick();
    endtask

    task automatic test_full_push();
        int n;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(t_sel[i], t_a[i], t_b[i]);
            tick();
        end
        idle();
        tick(); tick();
        // Full FIFO, pop and issue this cycle, command offered.
        drive(t_sel[6], t_a[6], t_b[6]);
        bus.res_ready = 1'b1;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.cmd_ready); end
        checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== t_res[0]) begin errors++; $display("FAIL full_head: got v=%b d=%h want v=1 d=%h", bus.res_valid, bus.res_data, t_res[0]); end
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.cmd_count !== 3'd3) begin errors++; $display("FAIL full_no_push: got %0d want 3", bus.cmd_count); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b want 1", bus.cmd_ready); end
        tick();
        idle();
        checks++; if (bus.cmd_count !== 3'd4) begin errors++; $display("FAIL full_late_push: got %0d want 4", bus.cmd_count); end
        bus.res_ready = 1'b1;
        n = 1;
        for (int k = 0; k < 40 && n < 7; k++) begin
            if (bus.res_valid) begin
                checks++;
                if (bus.res_data !== t_res[n] || bus.res_sel !== t_sel[n]) begin errors++; $display("FAIL full_drain%0d: got d=%h s=%b want d=%h s=%b", n, bus.res_data, bus.res_sel, t_res[n], t_sel[n]); end
                n++;
            end
            tick();
        end
        checks++; if (n != 7) begin errors++; $display("FAIL full_drain_count: got %0d want 7", n); end
        bus.res_ready = 1'b0;
        tick();
    endtask

    task automatic test_toggle_ready();
        int acc;
        int popped;
        int outst;
        acc = 0;
        popped = 0;
        for (int c = 0; c < 100 && popped < 8; c++) begin
            outst = acc - popped - int'(bus.cmd_count);
            checks++; if (outst < 0 || outst > 2) begin errors++; $display("FAIL toggle_outstanding c%0d: got %0d want 0..2", c, outst); end
            if (acc < 8) drive(t_sel[acc], t_a[acc], t_b[acc]);
            else idle();
            bus.res_ready = c[0];
            if (bus.cmd_valid && bus.cmd_ready) acc++;
            if (bus.res_valid && bus.res_ready) begin
                checks++;
                if (bus.res_data !== t_res[popped] || bus.res_sel !== t_sel[popped]) begin errors++; $display("FAIL toggle_result%0d: got d=%h s=%b want d=%h s=%b", popped, bus.res_data, bus.res_sel, t_res[popped], t_sel[popped]); end
                popped++;
            end
            tick();
        end
        idle();
        bus.res_ready = 1'b0;
        checks++; if (popped != 8) begin errors++; $display("FAIL toggle_count: got %0d want 8", popped); end
        tick();
    endtask

    task automatic test_reset_mid();
        int n;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(t_sel[i], t_a[i], t_b[i]);
            tick();
        end
        idle();
        tick(); tick();
        bus.res_ready = 1'b1;                     // one pop lets one command issue
        tick();
        bus.res_ready = 1'b0;
        checks++; if (bus.cmd_count !== 3'd3) begin errors++; $display("FAIL rstmid_queued: got %0d want 3", bus.cmd_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_res_valid: got %b want 0", bus.res_valid); end
        checks++; if (bus.cmd_count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", bus.cmd_count); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.res_data !== 8'h00) begin errors++; $display("FAIL rstmid_res_data: got %h want 00", bus.res_data); end
        bus.res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale%0d: got %b want 0", k, bus.res_valid); end
            tick();
        end
        drive(t_sel[6], t_a[6], t_b[6]);
        tick();
        idle();
        n = 0;
        for (int k = 0; k < 10 && n == 0; k++) begin
            if (bus.res_valid) begin
                checks++; if (bus.res_data !== t_res[6]) begin errors++; $display("FAIL rstmid_fresh: got %h want %h", bus.res_data, t_res[6]); end
                n++;
            end
            tick();
        end
        checks++; if (n != 1) begin errors++; $display("FAIL rstmid_fresh_count: got %0d want 1", n); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.res_ready = 1'b0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_stall();
        test_full_push();
        test_toggle_ready();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream command stage for the two-operand 8-bit ALU (ops: add, sub, add-constant, sub-constant; one register stage on its inputs). It accepts operation commands over a valid/ready interface, buffers them, and issues at most one per cycle onto the ALU's `sel`/`in1`/`in2` ports. It tracks the ALU's one-cycle latency and captures each `out` into a result queue. Results are presented in issue order over a second valid/ready interface, so the unhandshaked ALU can sit in a back-pressured pipeline.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2)
- `W`, 8: operand/result width (must match ALU)

- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset; shared with the ALU
- `cmd_valid` in 1: command offered
- `cmd_ready` out 1: command FIFO not full
- `cmd_sel` in 2: opcode
- `cmd_a` in W: operand A
- `cmd_b` in W: operand B
- `alu_sel` out 2: to ALU `sel`
- `alu_in1` out W: to ALU `in1`
- `alu_in2` out W: to ALU `in2`
- `alu_out` in W: from ALU `out`
- `res_valid` out 1: result available
- `res_ready` in 1: result consumed
- `res_data` out W: result value
- `res_sel` out 2: opcode that produced `res_data`
- `cmd_count` out $clog2(DEPTH)+1: command FIFO occupancy

## Operation
- Reset: both FIFOs empty, in-flight flag `f`=0. Outputs: `cmd_ready`=1, `res_valid`=0, `res_data`=0, `res_sel`=0, `cmd_count`=0, `alu_*`=0.
- Push: on `cmd_valid && cmd_ready`, write {sel,a,b}. `cmd_ready` = !full only. No pass-through when full, even if a pop happens in the same cycle.
- Issue condition: `issue = !cmd_empty && (f + rcnt - res_pop) < 2`.
  - `rcnt`: result FIFO occupancy (0..2).
  - `res_pop = res_valid && res_ready`.
- `alu_*` carry the head entry combinationally whenever the command FIFO is non-empty, and 0 otherwise. The head pops only on `issue`. The ALU captures `alu_*` every edge; values latched without `issue` are ignored because `f` stays 0.
- `f` is registered `issue`. When `f`=1, `alu_out` and the head-of-ALU opcode (a shadow register of the issued `sel`) are written into the result FIFO at that edge.
- Result FIFO is fixed at 2 entries. `res_data`/`res_sel` show its head. The issue condition makes overflow impossible; assert `!(f && rfull && !res_pop)`.
- ALU arithmetic is modulo 2^W: add 0x10+0x05=0x15; sub wraps; constant ops use 8'hAA.
- Ordering is strictly FIFO end to end.

## Timing
- Command accepted at edge t (end of cycle t) → issue in cycle t+1 at the earliest. There is no empty-FIFO bypass.
- Issue in cycle i → ALU registers at end of i → `alu_out` valid in i+1 → captured at end of i+1 → `res_valid` in i+2.
- Accept-to-`res_valid` minimum latency is 3 cycles.
- Throughput is 1 result/cycle with `res_ready` held high. Steady state: `f`=1, `rcnt`=1, pop each cycle.
- `res_ready`=0: at most 2 results are outstanding (in flight + queued), then issue stalls. The command FIFO then fills to `DEPTH` and `cmd_ready` drops the cycle after the last push.
- Simultaneous push and issue: occupancy unchanged. Simultaneous capture and pop in the result FIFO: occupancy unchanged.
- Pointers wrap modulo depth; full/empty use an extra pointer bit.
- `rst` mid-operation: all queued and in-flight commands are discarded. All outputs return to reset values at the next edge; the ALU is reset by the same `rst`.

## Structure
- Package `alu_seq_pkg`:
  - opcode constants `OP_ADD`=2'b00, `OP_SUB`=2'b01, `OP_ADDK`=2'b10, `OP_SUBK`=2'b11
  - `ALU_K`=8'hAA
  - the command struct {sel,a,b}
  - `ALU_LAT`=1
- Sub-module `sync_fifo` (parameters width and depth; push/pop/full/empty/count, synchronous active-high reset), instantiated twice: command FIFO at `DEPTH`, result FIFO at depth 2.

## Test plan
- Single ADD {00,0x10,0x05} accepted at cycle 0, `res_ready`=1 → `res_valid` in cycle 3, `res_data`=0x15, `res_sel`=00.
- Back-to-back SUB {01,0x05,0x10}, ADDK {10,0x60,x}, SUBK {11,x,0x00} → results 0xF5, 0x0A, 0x56 on consecutive cycles, in order.
- `res_ready`=0, push 6 commands → 2 issue, 4 held, `cmd_ready`=0, `cmd_count`=4. Raise `res_ready` → 6 results in push order, no loss.
- Full command FIFO with `cmd_valid` held and an issue in the same cycle → no push that cycle; push occurs the next cycle.
- `res_ready` toggled every cycle with a continuous command stream → never more than 2 outstanding, overflow assertion never fires, results ordered.
- `rst` pulsed with 3 commands queued and 1 in flight → next cycle `res_valid`=0, `cmd_count`=0, `cmd_ready`=1; no stale result ever appears.
